// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory behind the ALU with a fixed-latency wait-state controller.
// Holds the CPU via a combinational stall until each load or store completes, then pulses done/err.
module data_mem_ctrl #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [15:0]           rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [DEPTH_LOG2-1:0] addr_q;
    logic [15:0]           wdata_q;
    logic                  wr_q;
    logic                  inv_q;
    logic [15:0]           mem_q [DEPTH];

    logic                  req;
    logic                  req_inv;
    logic                  acc_en;
    logic [DEPTH_LOG2-1:0] acc_addr;
    logic [15:0]           acc_data;
    logic                  acc_wr;
    logic                  acc_inv;

    assign req     = mem_read | mem_write;
    assign req_inv = (mem_read & mem_write) | ((addr >> DEPTH_LOG2) != 16'd0);

    // With no wait cycles the access happens on the request edge itself, so it uses the live inputs.
    always_comb begin
        acc_en   = 1'b0;
        acc_addr = addr_q;
        acc_data = wdata_q;
        acc_wr   = wr_q;
        acc_inv  = inv_q;
        if (state_q == S_IDLE) begin
            acc_addr = addr[DEPTH_LOG2-1:0];
            acc_data = write_data;
            acc_wr   = mem_write;
            acc_inv  = req_inv;
            acc_en   = req && NO_WAIT;
        end else if (state_q == S_WAIT) begin
            acc_en = (cnt_q == 4'd0);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (NO_WAIT) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (acc_en) begin
            done_d = 1'b1;
            err_d  = acc_inv;
            if (acc_inv)      rdata_d = 16'd0;
            else if (!acc_wr) rdata_d = mem_q[acc_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 16'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Array and request latches carry no reset; a store cut off by rst is simply dropped.
    always_ff @(posedge clk) begin
        if (acc_en && acc_wr && !acc_inv && !rst) begin
            mem_q[acc_addr] <= acc_data;
        end
        if (state_q == S_IDLE && req) begin
            addr_q  <= addr[DEPTH_LOG2-1:0];
            wdata_q <= write_data;
            wr_q    <= mem_write;
            inv_q   <= req_inv;
        end
    end

    assign stall     = !rst && ((state_q == S_IDLE && req) || state_q == S_WAIT);
    assign read_data = rdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed table-driven bench for data_mem_ctrl: one instance with two wait cycles, one with none.
module tb_data_mem_ctrl;

    typedef struct {
        logic        r;
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [15:0] wd;
        logic        s;
        logic        d;
        logic        e;
        logic [15:0] q;
        logic        cq;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2 = 1'b1, rd2 = 1'b0, wr2 = 1'b0;
    logic [15:0] a2 = 16'd0, wd2 = 16'd0;
    logic [15:0] q2;
    logic        s2, d2, e2;

    logic        rst0 = 1'b1, rd0 = 1'b0, wr0 = 1'b0;
    logic [15:0] a0 = 16'd0, wd0 = 16'd0;
    logic [15:0] q0;
    logic        s0, d0, e0;

    int passed = 0;
    int total  = 0;

    vec_t t2[$];
    vec_t t0[$];

    data_mem_ctrl #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst2), .mem_read(rd2), .mem_write(wr2), .addr(a2),
        .write_data(wd2), .read_data(q2), .stall(s2), .done(d2), .err(e2)
    );

    data_mem_ctrl #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .mem_read(rd0), .mem_write(wr0), .addr(a0),
        .write_data(wd0), .read_data(q0), .stall(s0), .done(d0), .err(e0)
    );

    function automatic vec_t mk(input logic r, input logic rd, input logic wr,
                                input logic [15:0] a, input logic [15:0] wd,
                                input logic s, input logic d, input logic e,
                                input logic [15:0] q, input logic cq);
        vec_t v;
        v.r = r; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd;
        v.s = s; v.d = d; v.e = e; v.q = q; v.cq = cq;
        return v;
    endfunction

    // One full request as the CPU presents it: stall rows, then the done row with inputs still held.
    task automatic add_req(input bit to0, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [15:0] wd, input logic e,
                           input logic [15:0] qb, input logic cqb,
                           input logic [15:0] qa, input logic cqa);
        int n = to0 ? 1 : 3;
        for (int i = 0; i < n; i++) begin
            if (to0) t0.push_back(mk(1'b0, rd, wr, a, wd, 1'b1, 1'b0, 1'b0, qb, cqb));
            else     t2.push_back(mk(1'b0, rd, wr, a, wd, 1'b1, 1'b0, 1'b0, qb, cqb));
        end
        if (to0) t0.push_back(mk(1'b0, rd, wr, a, wd, 1'b0, 1'b1, e, qa, cqa));
        else     t2.push_back(mk(1'b0, rd, wr, a, wd, 1'b0, 1'b1, e, qa, cqa));
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        else passed++;
    endtask

    task automatic run_row(input bit to0, input vec_t v, input int idx);
        @(posedge clk);
        #1;
        if (to0) begin
            rst0 = v.r; rd0 = v.rd; wr0 = v.wr; a0 = v.a; wd0 = v.wd;
        end else begin
            rst2 = v.r; rd2 = v.rd; wr2 = v.wr; a2 = v.a; wd2 = v.wd;
        end
        #2;
        if (to0) begin
            chk("w0_stall", idx, {15'd0, s0}, {15'd0, v.s});
            chk("w0_done",  idx, {15'd0, d0}, {15'd0, v.d});
            chk("w0_err",   idx, {15'd0, e0}, {15'd0, v.e});
            if (v.cq) chk("w0_rdata", idx, q0, v.q);
        end else begin
            chk("w2_stall", idx, {15'd0, s2}, {15'd0, v.s});
            chk("w2_done",  idx, {15'd0, d2}, {15'd0, v.d});
            chk("w2_err",   idx, {15'd0, e2}, {15'd0, v.e});
            if (v.cq) chk("w2_rdata", idx, q2, v.q);
        end
    endtask

    initial begin
        int first, second, npulse;
        logic [15:0] qsecond;

        // Reset held with a load pending, then released: stall rises in the release cycle.
        t2.push_back(mk(1, 1, 0, 16'h0000, 16'h0, 0, 0, 0, 16'h0, 1));
        t2.push_back(mk(1, 1, 0, 16'h0000, 16'h0, 0, 0, 0, 16'h0, 1));
        t2.push_back(mk(0, 1, 0, 16'h0000, 16'h0, 1, 0, 0, 16'h0, 1));
        t2.push_back(mk(0, 1, 0, 16'h0000, 16'h0, 1, 0, 0, 16'h0, 1));
        t2.push_back(mk(0, 1, 0, 16'h0000, 16'h0, 1, 0, 0, 16'h0, 1));
        t2.push_back(mk(0, 1, 0, 16'h0000, 16'h0, 0, 1, 0, 16'h0, 0));
        t2.push_back(mk(0, 0, 0, 16'h0000, 16'h0, 0, 0, 0, 16'h0, 0));
        add_req(0, 0, 1, 16'h0012, 16'hBEEF, 0, 16'h0, 0, 16'h0, 0);
        add_req(0, 1, 0, 16'h0012, 16'h0000, 0, 16'h0, 0, 16'hBEEF, 1);
        add_req(0, 0, 1, 16'h0000, 16'h0F0F, 0, 16'hBEEF, 1, 16'hBEEF, 1);
        add_req(0, 0, 1, 16'h0100, 16'h1234, 1, 16'hBEEF, 1, 16'h0000, 1);
        add_req(0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0F0F, 1);
        add_req(0, 1, 1, 16'h0012, 16'h4321, 1, 16'h0F0F, 1, 16'h0000, 1);
        add_req(0, 0, 1, 16'h0007, 16'h1111, 0, 16'h0000, 1, 16'h0000, 1);
        add_req(0, 1, 0, 16'h0012, 16'h0000, 0, 16'h0000, 1, 16'hBEEF, 1);
        // Store 0x5555 to 7 aborted by reset in its second WAIT cycle; no done afterwards.
        t2.push_back(mk(0, 0, 1, 16'h0007, 16'h5555, 1, 0, 0, 16'hBEEF, 1));
        t2.push_back(mk(0, 0, 1, 16'h0007, 16'h5555, 1, 0, 0, 16'hBEEF, 1));
        t2.push_back(mk(1, 0, 1, 16'h0007, 16'h5555, 0, 0, 0, 16'h0000, 1));
        t2.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1));
        t2.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1));
        add_req(0, 1, 0, 16'h0007, 16'h0000, 0, 16'h0000, 1, 16'h1111, 1);
        // Address moves from 5 to 9 during WAIT; the latched address must win.
        add_req(0, 0, 1, 16'h0009, 16'h9999, 0, 16'h1111, 1, 16'h1111, 1);
        t2.push_back(mk(0, 0, 1, 16'h0005, 16'hAAAA, 1, 0, 0, 16'h1111, 1));
        t2.push_back(mk(0, 0, 1, 16'h0009, 16'h7777, 1, 0, 0, 16'h1111, 1));
        t2.push_back(mk(0, 0, 1, 16'h0009, 16'h7777, 1, 0, 0, 16'h1111, 1));
        t2.push_back(mk(0, 0, 1, 16'h0009, 16'h7777, 0, 1, 0, 16'h1111, 1));
        add_req(0, 1, 0, 16'h0005, 16'h0000, 0, 16'h1111, 1, 16'hAAAA, 1);
        add_req(0, 1, 0, 16'h0009, 16'h0000, 0, 16'hAAAA, 1, 16'h9999, 1);
        t2.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h9999, 1));

        t0.push_back(mk(1, 0, 0, 16'h0000, 16'h0, 0, 0, 0, 16'h0, 1));
        t0.push_back(mk(0, 0, 0, 16'h0000, 16'h0, 0, 0, 0, 16'h0, 1));
        add_req(1, 0, 1, 16'h0003, 16'h0303, 0, 16'h0, 1, 16'h0, 1);
        add_req(1, 0, 1, 16'h0004, 16'h0404, 0, 16'h0, 1, 16'h0, 1);
        add_req(1, 1, 0, 16'h0003, 16'h0000, 0, 16'h0, 1, 16'h0303, 1);
        t0.push_back(mk(0, 0, 0, 16'h0000, 16'h0, 0, 0, 0, 16'h0303, 1));

        foreach (t2[i]) run_row(1'b0, t2[i], i);
        foreach (t0[i]) run_row(1'b1, t0[i], i);

        // Back-to-back loads of 3 and 4 with no wait cycles: two done pulses two cycles apart.
        first = -1; second = -1; npulse = 0; qsecond = 16'h0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            rd0 = (k < 4);
            wr0 = 1'b0;
            a0  = (k < 2) ? 16'h0003 : 16'h0004;
            #2;
            if (d0) begin
                npulse++;
                if (first < 0) first = k;
                else if (second < 0) begin
                    second  = k;
                    qsecond = q0;
                end
            end
        end
        chk("b2b_pulses", 0, 16'(npulse), 16'd2);
        chk("b2b_gap",    0, 16'(second - first), 16'd2);
        chk("b2b_rdata",  0, qsecond, 16'h0404);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
